window_shift_param: RTL and testbench

- Parametrised horizontal window generator for the SGM disparity pipeline.
- Takes ROWS line-buffer row streams and shifts each into a DEPTH-tap register chain, presenting every tap in parallel to the cost/aggregation stage.
- Supersedes the fixed 4-row/255-tap window with these additions:
  - frame-aware start via sof;
  - a column tracker;
  - optional zero-masking of taps that would wrap into the previous line;
  - a restart on a new frame.

---
 rtl/window_shift_param.sv | 124 ++++++++++++
 tb/tb_window_shift_param.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/window_shift_param.sv
// Horizontal window generator: each of ROWS pixel streams shifts through a DEPTH-tap chain,
// with frame-aware restart on sof, a column tracker and optional left-border zero masking.
module window_shift_param #(
  parameter int PIXEL_WIDTH = 8,
  parameter int ROWS        = 4,
  parameter int DEPTH       = 255,
  parameter int BORDER_ZERO = 1
) (
  input  logic                               clock,
  input  logic                               rst,
  input  logic                               clken,
  input  logic                               sof,
  input  logic [10:0]                        width,
  input  logic [PIXEL_WIDTH*ROWS-1:0]        linebuffer,
  output logic [PIXEL_WIDTH*ROWS*DEPTH-1:0]  win_pixel,
  output logic [10:0]                        tap0_col,
  output logic                               en,
  output logic                               busy
);

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  localparam logic [21:0] FillMax = '1;

  state_e                 state_q, state_d;
  logic [21:0]            fill_q, fill_d;
  logic [10:0]            width_q, width_d;
  logic [10:0]            col_q, col_d;
  logic                   en_q, en_d;
  logic [PIXEL_WIDTH-1:0] taps_q [ROWS][DEPTH];

  logic        start;
  logic        advance;
  logic [21:0] fill_inc;
  logic [21:0] target;

  // A sof with zero width is not a frame start; in FILL/RUN that pixel shifts in as usual.
  assign start    = clken & sof & (width != 11'd0);
  assign advance  = clken & ~start & (state_q != StIdle);
  assign fill_inc = fill_q + 22'd1;
  assign target   = 22'(ROWS) * {11'd0, width_q};

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    width_d = width_q;
    col_d   = col_q;
    en_d    = en_q;
    if (start) begin
      width_d = width;
      fill_d  = 22'd1;
      col_d   = 11'd0;
      en_d    = 1'b0;
      state_d = StFill;
    end else if (advance) begin
      fill_d = (fill_q == FillMax) ? fill_q : fill_inc;
      col_d  = (col_q == width_q - 11'd1) ? 11'd0 : col_q + 11'd1;
      if (state_q == StFill && fill_inc >= target) begin
        en_d    = 1'b1;
        state_d = StRun;
      end
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      fill_q  <= '0;
      width_q <= '0;
      col_q   <= '0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      width_q <= width_d;
      col_q   <= col_d;
      en_q    <= en_d;
    end
  end

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) begin
        for (int k = 0; k < DEPTH; k++) begin
          taps_q[r][k] <= '0;
        end
      end
    end else if (start) begin
      for (int r = 0; r < ROWS; r++) begin
        taps_q[r][0] <= linebuffer[r*PIXEL_WIDTH +: PIXEL_WIDTH];
        for (int k = 1; k < DEPTH; k++) begin
          taps_q[r][k] <= '0;
        end
      end
    end else if (advance) begin
      for (int r = 0; r < ROWS; r++) begin
        taps_q[r][0] <= linebuffer[r*PIXEL_WIDTH +: PIXEL_WIDTH];
        for (int k = 1; k < DEPTH; k++) begin
          taps_q[r][k] <= taps_q[r][k-1];
        end
      end
    end
  end

  // Tap 0 is the MSB slice of each row block; taps past the current column belong to the
  // previous line and are masked when BORDER_ZERO is set.
  always_comb begin
    win_pixel = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (BORDER_ZERO != 0 && k > int'(col_q)) begin
          win_pixel[r*PIXEL_WIDTH*DEPTH + (DEPTH-1-k)*PIXEL_WIDTH +: PIXEL_WIDTH] = '0;
        end else begin
          win_pixel[r*PIXEL_WIDTH*DEPTH + (DEPTH-1-k)*PIXEL_WIDTH +: PIXEL_WIDTH] = taps_q[r][k];
        end
      end
    end
  end

  assign tap0_col = col_q;
  assign en       = en_q;
  assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_window_shift_param.sv
module tb_window_shift_param;

  localparam int PW = 8;
  localparam int NR = 4;
  localparam int ND = 8;
  localparam int WW = PW * NR * ND;

  localparam int KTap  = 0;
  localparam int KCol  = 1;
  localparam int KEn   = 2;
  localparam int KBusy = 3;
  localparam int KZero = 4;

  typedef struct {
    string name;
    int    kind;
    int    dut;
    int    row;
    int    tap;
    int    exp;
  } chk_t;

  logic              clock = 1'b0;
  logic              rst;
  logic              clken;
  logic              sof;
  logic [10:0]       width;
  logic [PW*NR-1:0]  lb;
  logic [WW-1:0]     win_raw, win_bz;
  logic [10:0]       col_raw, col_bz;
  logic              en_raw, en_bz, busy_raw, busy_bz;

  chk_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  bit   done     = 1'b0;

  always #5 clock = ~clock;

  window_shift_param #(
    .PIXEL_WIDTH(PW), .ROWS(NR), .DEPTH(ND), .BORDER_ZERO(0)
  ) u_raw (
    .clock(clock), .rst(rst), .clken(clken), .sof(sof), .width(width), .linebuffer(lb),
    .win_pixel(win_raw), .tap0_col(col_raw), .en(en_raw), .busy(busy_raw)
  );

  window_shift_param #(
    .PIXEL_WIDTH(PW), .ROWS(NR), .DEPTH(ND), .BORDER_ZERO(1)
  ) u_bz (
    .clock(clock), .rst(rst), .clken(clken), .sof(sof), .width(width), .linebuffer(lb),
    .win_pixel(win_bz), .tap0_col(col_bz), .en(en_bz), .busy(busy_bz)
  );

  function automatic int actual(chk_t c);
    logic [WW-1:0] w;
    w = (c.dut != 0) ? win_bz : win_raw;
    case (c.kind)
      KTap:    return int'(w[c.row*PW*ND + (ND-1-c.tap)*PW +: PW]);
      KCol:    return int'((c.dut != 0) ? col_bz : col_raw);
      KEn:     return int'((c.dut != 0) ? en_bz : en_raw);
      KBusy:   return int'((c.dut != 0) ? busy_bz : busy_raw);
      default: return (w == '0) ? 0 : 1;
    endcase
  endfunction

  always @(negedge clock) begin
    while (sb.size() > 0) begin
      chk_t c;
      int   a;
      c = sb.pop_front();
      a = actual(c);
      checks++;
      if (a != c.exp) begin
        failures++;
        $display("FAIL %s: actual=0x%0h required=0x%0h", c.name, a, c.exp);
      end
    end
  end

  task automatic check_now(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      failures++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", n, a, e);
    end
  endtask

  task automatic push(input string n, input int kind, input int dut, input int row,
                      input int tap, input int e);
    chk_t c;
    c.name = n;
    c.kind = kind;
    c.dut  = dut;
    c.row  = row;
    c.tap  = tap;
    c.exp  = e;
    sb.push_back(c);
  endtask

  // One accepted pixel; row r carries p + 0x10*r.
  task automatic pix(input logic s, input logic [7:0] p);
    lb    = {p + 8'h30, p + 8'h20, p + 8'h10, p};
    sof   = s;
    clken = 1'b1;
    @(posedge clock);
    #1;
    clken = 1'b0;
    sof   = 1'b0;
  endtask

  initial begin
    #100000;
    if (!done) begin
      failures++;
      $display("FAIL timeout: stimulus did not complete");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    rst   = 1'b0;
    clken = 1'b0;
    sof   = 1'b0;
    width = 11'd16;
    lb    = '0;
    repeat (2) @(posedge clock);
    #1 rst = 1'b1;

    check_now("reset_direct_win_raw_zero", (win_raw == '0) ? 0 : 1, 0);
    check_now("reset_direct_win_bz_zero", (win_bz == '0) ? 0 : 1, 0);
    check_now("reset_direct_col", int'(col_raw), 0);
    check_now("reset_direct_en", int'(en_raw), 0);
    check_now("reset_direct_busy", int'(busy_bz), 0);

    push("reset_win_raw_zero", KZero, 0, 0, 0, 0);
    push("reset_win_bz_zero", KZero, 1, 0, 0, 0);
    push("reset_col", KCol, 0, 0, 0, 0);
    push("reset_en", KEn, 0, 0, 0, 0);
    push("reset_busy", KBusy, 1, 0, 0, 0);

    for (int i = 0; i < 10; i++) pix(1'b0, 8'h55);
    push("idle_win_zero", KZero, 0, 0, 0, 0);
    push("idle_en", KEn, 0, 0, 0, 0);
    push("idle_busy", KBusy, 0, 0, 0, 0);
    push("idle_col", KCol, 0, 0, 0, 0);

    width = 11'd0;
    pix(1'b1, 8'h77);
    push("sof_width0_busy", KBusy, 0, 0, 0, 0);
    push("sof_width0_win_zero", KZero, 0, 0, 0, 0);
    width = 11'd16;

    pix(1'b1, 8'd1);
    push("sof_busy", KBusy, 0, 0, 0, 1);
    push("sof_en", KEn, 0, 0, 0, 0);
    for (int i = 2; i <= 8; i++) pix(1'b0, 8'(i));
    push("fill8_r0_t0", KTap, 0, 0, 0, 8);
    push("fill8_r0_t7", KTap, 0, 0, 7, 1);
    push("fill8_r1_t0", KTap, 0, 1, 0, 8'h18);
    push("fill8_col", KCol, 0, 0, 0, 7);
    push("fill8_bz_r0_t7", KTap, 1, 0, 7, 1);
    for (int i = 9; i <= 63; i++) pix(1'b0, 8'(i));
    push("fill63_en_raw", KEn, 0, 0, 0, 0);
    push("fill63_en_bz", KEn, 1, 0, 0, 0);
    push("fill63_busy", KBusy, 0, 0, 0, 1);
    pix(1'b0, 8'd64);
    push("fill64_en_raw", KEn, 0, 0, 0, 1);
    push("fill64_en_bz", KEn, 1, 0, 0, 1);
    push("fill64_r0_t0", KTap, 0, 0, 0, 64);
    push("fill64_r0_t3", KTap, 0, 0, 3, 61);
    push("fill64_r3_t7", KTap, 0, 3, 7, 8'h69);
    push("fill64_col", KCol, 0, 0, 0, 15);

    // Width change without sof must not alter the column wrap point.
    width = 11'd5;
    for (int i = 0; i < 5; i++) begin
      lb = (i % 2 == 0) ? '1 : '0;
      @(posedge clock);
      #1;
    end
    push("hold_r0_t0", KTap, 0, 0, 0, 64);
    push("hold_r0_t1", KTap, 0, 0, 1, 63);
    push("hold_col", KCol, 0, 0, 0, 15);
    push("hold_en", KEn, 0, 0, 0, 1);
    pix(1'b0, 8'd65);
    push("resume_r0_t0", KTap, 0, 0, 0, 65);
    push("resume_r0_t1", KTap, 0, 0, 1, 64);
    push("resume_col_wrap", KCol, 0, 0, 0, 0);
    push("resume_bz_t1_masked", KTap, 1, 0, 1, 0);
    push("resume_bz_t0", KTap, 1, 0, 0, 65);
    width = 11'd16;

    pix(1'b1, 8'h3C);
    push("restart_r0_t0", KTap, 0, 0, 0, 8'h3C);
    push("restart_r0_t1", KTap, 0, 0, 1, 0);
    push("restart_r2_t7", KTap, 0, 2, 7, 0);
    push("restart_col", KCol, 0, 0, 0, 0);
    push("restart_en", KEn, 0, 0, 0, 0);
    push("restart_busy", KBusy, 0, 0, 0, 1);
    push("restart_bz_r1_t0", KTap, 1, 1, 0, 8'h4C);
    for (int j = 1; j <= 62; j++) pix(1'b0, 8'(j));
    push("restart63_en", KEn, 0, 0, 0, 0);
    pix(1'b0, 8'd63);
    push("restart64_en", KEn, 0, 0, 0, 1);
    push("restart64_col", KCol, 0, 0, 0, 15);

    pix(1'b1, 8'hAA);
    for (int i = 2; i <= 17; i++) pix(1'b0, 8'hAA);
    push("mask17_bz_t0", KTap, 1, 0, 0, 8'hAA);
    push("mask17_bz_t1", KTap, 1, 0, 1, 0);
    push("mask17_bz_t7", KTap, 1, 0, 7, 0);
    push("mask17_bz_col", KCol, 1, 0, 0, 0);
    push("mask17_raw_t1", KTap, 0, 0, 1, 8'hAA);
    push("mask17_raw_t7", KTap, 0, 0, 7, 8'hAA);
    pix(1'b0, 8'hAA);
    push("mask18_bz_t0", KTap, 1, 0, 0, 8'hAA);
    push("mask18_bz_t1", KTap, 1, 0, 1, 8'hAA);
    push("mask18_bz_t2", KTap, 1, 0, 2, 0);
    push("mask18_bz_t7", KTap, 1, 0, 7, 0);
    push("mask18_bz_col", KCol, 1, 0, 0, 1);

    for (int i = 19; i <= 64; i++) pix(1'b0, 8'(i));
    push("prerst_en", KEn, 0, 0, 0, 1);
    @(negedge clock);

    @(posedge clock);
    #2 rst = 1'b0;
    #1;
    check_now("async_rst_direct_win_raw", (win_raw == '0) ? 0 : 1, 0);
    check_now("async_rst_direct_win_bz", (win_bz == '0) ? 0 : 1, 0);
    check_now("async_rst_direct_col", int'(col_raw), 0);
    check_now("async_rst_direct_en", int'(en_raw), 0);
    check_now("async_rst_direct_busy", int'(busy_raw), 0);
    push("async_rst_win_raw", KZero, 0, 0, 0, 0);
    push("async_rst_win_bz", KZero, 1, 0, 0, 0);
    push("async_rst_col", KCol, 0, 0, 0, 0);
    push("async_rst_en", KEn, 0, 0, 0, 0);
    push("async_rst_busy", KBusy, 0, 0, 0, 0);
    @(negedge clock);
    #1 rst = 1'b1;

    pix(1'b0, 8'h11);
    push("postrst_busy", KBusy, 0, 0, 0, 0);
    push("postrst_win_zero", KZero, 0, 0, 0, 0);
    @(negedge clock);
    #1;

    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
